framebuf_writer: RTL and testbench

FRAMEBUF_WRITER -- requirements
Module: framebuf_writer

---
 rtl/framebuf_writer_if.sv | 22 ++
 rtl/framebuf_writer.sv | 120 ++++++++++++
 tb/tb_framebuf_writer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/framebuf_writer_if.sv
// Cell-write request channel and frame-buffer write port of framebuf_writer.
// The master side issues write requests; the slave side drives the memory write port.
interface framebuf_writer_if;
  logic       req_valid;
  logic       req_ready;
  logic [4:0] req_x;
  logic [4:0] req_y;
  logic [4:0] req_data;
  logic       we;
  logic [9:0] waddr;
  logic [4:0] wdata;

  modport master (
    output req_valid, req_x, req_y, req_data,
    input  req_ready, we, waddr, wdata
  );

  modport slave (
    input  req_valid, req_x, req_y, req_data,
    output req_ready, we, waddr, wdata
  );
endinterface

// File: rtl/framebuf_writer.sv
// Queues block-cell writes and commits them to the VGA frame buffer only during vblank;
// also performs full-screen clear sweeps after reset and on request.
module framebuf_writer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [4:0]  CLEAR_DATA = 5'd0,
  parameter int unsigned COLS       = 32,
  parameter int unsigned ROWS       = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vblank,
  input  logic              clear_req,
  output logic              busy,
  output logic              oob,
  framebuf_writer_if.slave  bus
);

  localparam int unsigned AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [5:0]  COLS_L   = 6'(COLS);
  localparam logic [5:0]  ROWS_L   = 6'(ROWS);
  localparam logic [4:0]  XMAX     = 5'(COLS - 1);
  localparam logic [4:0]  YMAX     = 5'(ROWS - 1);

  typedef enum logic [1:0] {CLEAR, IDLE, DRAIN} state_t;

  state_t        state;
  logic [4:0]    sx;
  logic [4:0]    sy;
  logic [14:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic          accept;
  logic          in_range;
  logic          push;
  logic          pop;

  // reset gates ready/busy combinationally so they are correct while reset is held
  assign bus.req_ready = reset & (state != CLEAR) & (count != FULL_CNT) & ~clear_req;
  assign busy          = ~reset | (state == CLEAR) | (count != '0);

  always_comb begin
    accept    = bus.req_valid & bus.req_ready;
    in_range  = ({1'b0, bus.req_x} < COLS_L) & ({1'b0, bus.req_y} < ROWS_L);
    push      = accept & in_range;
    pop       = (state == DRAIN) & vblank & (count != '0);
    count_nxt = count;
    if (push & ~pop)
      count_nxt = count + 1'b1;
    else if (pop & ~push)
      count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wptr] <= {bus.req_x, bus.req_y, bus.req_data};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= CLEAR;
      sx        <= '0;
      sy        <= '0;
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      bus.we    <= 1'b0;
      bus.waddr <= '0;
      bus.wdata <= '0;
      oob       <= 1'b0;
    end else begin
      bus.we <= 1'b0;
      oob    <= accept & ~in_range;
      if (clear_req) begin
        // pending entries are dropped, not written
        state <= CLEAR;
        sx    <= '0;
        sy    <= '0;
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (push)
          wptr <= wptr + 1'b1;
        if (pop) begin
          rptr                   <= rptr + 1'b1;
          bus.we                 <= 1'b1;
          {bus.waddr, bus.wdata} <= mem[rptr];
        end
        count <= count_nxt;
        unique case (state)
          CLEAR: begin
            if (vblank) begin
              bus.we    <= 1'b1;
              bus.waddr <= {sx, sy};
              bus.wdata <= CLEAR_DATA;
              if (sx == XMAX) begin
                sx <= '0;
                if (sy == YMAX) begin
                  sy    <= '0;
                  state <= IDLE;
                end else begin
                  sy <= sy + 5'd1;
                end
              end else begin
                sx <= sx + 5'd1;
              end
            end
          end
          IDLE:    if (count != '0) state <= DRAIN;
          DRAIN:   if (count_nxt == '0) state <= IDLE;
          default: state <= CLEAR;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_framebuf_writer.sv
// Randomized scoreboard bench for framebuf_writer: expected frame-buffer writes are
// queued from the clear/enqueue rules and matched in order against the write port.
module tb_framebuf_writer;
  localparam int         DEPTH = 4;
  localparam int         COLS  = 32;
  localparam int         ROWS  = 24;
  localparam logic [4:0] CLR   = 5'd0;

  logic clk = 1'b0;
  logic reset, vblank, clear_req, busy, oob;

  framebuf_writer_if bus();

  framebuf_writer #(
    .FIFO_DEPTH(DEPTH), .CLEAR_DATA(CLR), .COLS(COLS), .ROWS(ROWS)
  ) dut (
    .clk(clk), .reset(reset), .vblank(vblank), .clear_req(clear_req),
    .busy(busy), .oob(oob), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct { logic [9:0] addr; logic [4:0] data; bit sweep; } wr_t;

  wr_t  exp_q[$];
  int   n_sweep = 0, n_fifo = 0, n_writes = 0;
  int   n_checks = 0, n_fail = 0;
  bit   exp_oob = 1'b0, mon_en = 1'b0;
  bit   acc_s, rst_s, clr_s;
  logic [4:0] x_s, y_s, d_s;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual %0h required %0h", name, $time, act, exp);
    end
  endtask

  // Expected effect of a clear: every cell in row-major order, pending requests forgotten
  task automatic load_sweep();
    exp_q.delete();
    n_fifo  = 0;
    n_sweep = 0;
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++) begin
        exp_q.push_back('{addr: {5'(x), 5'(y)}, data: CLR, sweep: 1'b1});
        n_sweep++;
      end
  endtask

  // One clock: sample the handshake mid-cycle, apply the reference rules at the edge
  task automatic cyc();
    @(negedge clk);
    acc_s = bus.req_valid & bus.req_ready;
    rst_s = reset;
    clr_s = clear_req;
    x_s = bus.req_x; y_s = bus.req_y; d_s = bus.req_data;
    @(posedge clk);
    exp_oob = 1'b0;
    if (!rst_s || clr_s) begin
      load_sweep();
    end else if (acc_s) begin
      if (int'(x_s) < COLS && int'(y_s) < ROWS) begin
        exp_q.push_back('{addr: {x_s, y_s}, data: d_s, sweep: 1'b0});
        n_fifo++;
      end else begin
        exp_oob = 1'b1;
      end
    end
    #1;
  endtask

  task automatic push(input logic [4:0] x, input logic [4:0] y, input logic [4:0] d,
                      input int bound);
    int i;
    bus.req_valid = 1'b1; bus.req_x = x; bus.req_y = y; bus.req_data = d;
    i = 0;
    do begin cyc(); i++; end while (!acc_s && i < bound);
    bus.req_valid = 1'b0;
    chk("push_accept", acc_s, 1);
  endtask

  task automatic drain(input int bound, input string name);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < bound) begin cyc(); i++; end
    chk(name, exp_q.size(), 0);
  endtask

  // Monitor: in-order write matching plus per-cycle ready/busy/oob checks
  initial begin : monitor
    bit vb_p, rst_p, clr_p;
    int sweep_p;
    wr_t e;
    vb_p = 1'b0; rst_p = 1'b0; clr_p = 1'b0; sweep_p = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (bus.we === 1'b1) begin
          n_writes++;
          chk("write_in_vblank", vb_p, 1);
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_write at %0t: actual addr %0h data %0h required no write",
                     $time, bus.waddr, bus.wdata);
          end else begin
            e = exp_q.pop_front();
            chk("write", {bus.waddr, bus.wdata}, {e.addr, e.data});
            if (e.sweep) n_sweep--; else n_fifo--;
          end
        end else if (rst_p && !clr_p && vb_p && sweep_p > 0) begin
          chk("sweep_stall", bus.we, 1);
        end
        chk("oob", oob, exp_oob);
        chk("busy", busy, (!reset || exp_q.size() != 0));
        chk("req_ready", bus.req_ready,
            (reset && !clear_req && n_sweep == 0 && n_fifo < DEPTH));
      end
      vb_p = vblank; rst_p = reset; clr_p = clear_req; sweep_p = n_sweep;
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    int i, w0;
    reset = 1'b0; vblank = 1'b1; clear_req = 1'b0;
    bus.req_valid = 1'b0; bus.req_x = '0; bus.req_y = '0; bus.req_data = '0;
    cyc();
    mon_en = 1'b1;
    chk("reset_we", bus.we, 0);
    chk("reset_waddr", bus.waddr, 0);
    repeat (2) cyc();

    // power-up sweep
    reset = 1'b1;
    w0 = n_writes;
    drain(2000, "powerup_drain");
    chk("powerup_writes", n_writes - w0, 768);
    chk("ready_after_clear", bus.req_ready, 1);
    chk("busy_after_clear", busy, 0);

    // vblank gap mid-sweep after {5,3}
    clear_req = 1'b1; cyc(); clear_req = 1'b0;
    i = 0;
    while (!(bus.we === 1'b1 && bus.waddr == {5'd5, 5'd3}) && i < 400) begin cyc(); i++; end
    chk("saw_5_3", bus.waddr, {5'd5, 5'd3});
    vblank = 1'b0;
    repeat (100) begin cyc(); chk("gap_we", bus.we, 0); end
    vblank = 1'b1;
    i = 0;
    do begin cyc(); i++; end while (bus.we !== 1'b1 && i < 5);
    chk("resume_addr", bus.waddr, {5'd6, 5'd3});
    drain(2000, "gap_drain");

    // FIFO full: 4 pushes outside vblank, 5th blocks until draining starts
    vblank = 1'b0;
    for (int k = 0; k < 4; k++)
      push(5'($urandom_range(31)), 5'($urandom_range(23)), 5'($urandom), 10);
    bus.req_valid = 1'b1; bus.req_x = 5'd31; bus.req_y = 5'd23; bus.req_data = 5'($urandom);
    repeat (3) begin cyc(); chk("full_blocks", acc_s, 0); end
    vblank = 1'b1;
    i = 0;
    do begin cyc(); i++; end while (!acc_s && i < 20);
    bus.req_valid = 1'b0;
    chk("fifth_accepted", acc_s, 1);
    drain(50, "full_drain");

    // out-of-range row
    push(5'd3, 5'd24, 5'($urandom), 5);
    chk("oob_pulse", oob, 1);
    cyc();
    chk("oob_once", oob, 0);
    chk("oob_not_busy", busy, 0);

    // clear with 3 pending entries
    vblank = 1'b0;
    for (int k = 0; k < 3; k++)
      push(5'($urandom_range(31)), 5'($urandom_range(23)), 5'($urandom), 10);
    clear_req = 1'b1; cyc(); clear_req = 1'b0;
    vblank = 1'b1;
    w0 = n_writes;
    drain(2000, "clear_drain");
    chk("clear_writes", n_writes - w0, 768);

    // reset during DRAIN
    vblank = 1'b0;
    for (int k = 0; k < 3; k++)
      push(5'($urandom_range(31)), 5'($urandom_range(23)), 5'($urandom), 10);
    vblank = 1'b1;
    cyc();
    reset = 1'b0; cyc(); reset = 1'b1;
    chk("rst_we", bus.we, 0);
    chk("rst_busy", busy, 1);
    w0 = n_writes;
    drain(2000, "rst_drain");
    chk("rst_writes", n_writes - w0, 768);

    // random traffic, including out-of-range coordinates and rare clears
    for (int c = 0; c < 800; c++) begin
      vblank        = ($urandom_range(3) != 0);
      clear_req     = ($urandom_range(399) == 0);
      bus.req_valid = $urandom_range(1);
      bus.req_x     = 5'($urandom_range(33));
      bus.req_y     = 5'($urandom_range(25));
      bus.req_data  = 5'($urandom);
      cyc();
    end
    clear_req = 1'b0; bus.req_valid = 1'b0; vblank = 1'b1;
    drain(3000, "random_drain");
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
